// File: rtl/cl_fsb_cfg_initiator.sv
// cl_fsb_cfg_initiator: AXI4-Lite (OCL) to cfg-bus initiator bridge.
// Build option: define CFG_INIT_TIMEOUT_EN for cfg_ack timeout with SLVERR.
module cl_fsb_cfg_initiator #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = 32'hDEAD_DEAD
) (
    input  logic        clk_main_a0,
    input  logic        rst_main_n,
    input  logic        s_awvalid,
    input  logic [31:0] s_awaddr,
    output logic        s_awready,
    input  logic        s_wvalid,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    output logic        s_wready,
    output logic        s_bvalid,
    output logic [1:0]  s_bresp,
    input  logic        s_bready,
    input  logic        s_arvalid,
    input  logic [31:0] s_araddr,
    output logic        s_arready,
    output logic        s_rvalid,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    input  logic        s_rready,
    output logic [31:0] cfg_addr,
    output logic [31:0] cfg_wdata,
    output logic        cfg_wr,
    output logic        cfg_rd,
    input  logic        cfg_ack,
    input  logic [31:0] cfg_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        RD_REQ,
        WR_RESP,
        RD_RESP
    } state_t;

    localparam logic       RR_READ  = 1'b0;
    localparam logic       RR_WRITE = 1'b1;
    localparam logic [1:0] OKAY     = 2'b00;
    localparam logic [1:0] SLVERR   = 2'b10;

    state_t      state;
    logic        aw_held;
    logic        w_held;
    logic [31:0] awaddr_q;
    logic [31:0] wdata_q;
    logic        rr_last;

    logic        idle;
    logic        wr_rdy;
    logic        rd_rdy;
    logic        grant_wr;
    logic        grant_rd;
    logic        req_err;
    logic        req_done;
    logic        unused_ok;

    assign idle      = (state == IDLE);
    assign s_awready = idle & ~aw_held;
    assign s_wready  = idle & ~w_held;

    // Write needs both halves registered; a read only needs AR present.
    assign wr_rdy   = aw_held & w_held;
    assign rd_rdy   = s_arvalid;
    assign grant_wr = idle & wr_rdy & (~rd_rdy | (rr_last == RR_READ));
    assign grant_rd = idle & rd_rdy & ~grant_wr;

    // AR is only accepted in the cycle the read wins arbitration.
    assign s_arready = grant_rd;

`ifdef CFG_INIT_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    logic [15:0] tmo_cnt;

    assign req_err   = ~cfg_ack & (tmo_cnt == TMO_LAST);
    assign unused_ok = ^s_wstrb;

    // Count request cycles without ack; restarts on every grant.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            tmo_cnt <= '0;
        end else if (grant_wr | grant_rd) begin
            tmo_cnt <= '0;
        end else if ((state == WR_REQ || state == RD_REQ) && !cfg_ack) begin
            tmo_cnt <= tmo_cnt + 16'd1;
        end
    end
`else
    assign req_err   = 1'b0;
    assign unused_ok = ^{s_wstrb, TIMEOUT_CYCLES};
`endif

    // Ack always wins over a simultaneous terminal count.
    assign req_done = cfg_ack | req_err;

    // Host capture, arbitration and cfg request/response sequencing.
    always_ff @(posedge clk_main_a0 or negedge rst_main_n) begin
        if (!rst_main_n) begin
            state     <= IDLE;
            aw_held   <= 1'b0;
            w_held    <= 1'b0;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            rr_last   <= RR_READ;
            cfg_addr  <= '0;
            cfg_wdata <= '0;
            cfg_wr    <= 1'b0;
            cfg_rd    <= 1'b0;
            s_bvalid  <= 1'b0;
            s_bresp   <= OKAY;
            s_rvalid  <= 1'b0;
            s_rdata   <= '0;
            s_rresp   <= OKAY;
        end else begin
            if (s_awvalid && s_awready) begin
                aw_held  <= 1'b1;
                awaddr_q <= s_awaddr;
            end
            if (s_wvalid && s_wready) begin
                w_held  <= 1'b1;
                wdata_q <= s_wdata;
            end
            unique case (state)
                IDLE: begin
                    if (grant_wr) begin
                        cfg_addr  <= awaddr_q;
                        cfg_wdata <= wdata_q;
                        cfg_wr    <= 1'b1;
                        state     <= WR_REQ;
                    end else if (grant_rd) begin
                        cfg_addr <= s_araddr;
                        cfg_rd   <= 1'b1;
                        state    <= RD_REQ;
                    end
                end
                WR_REQ: begin
                    if (req_done) begin
                        cfg_wr   <= 1'b0;
                        s_bvalid <= 1'b1;
                        s_bresp  <= cfg_ack ? OKAY : SLVERR;
                        state    <= WR_RESP;
                    end
                end
                RD_REQ: begin
                    if (req_done) begin
                        cfg_rd   <= 1'b0;
                        s_rvalid <= 1'b1;
                        s_rresp  <= cfg_ack ? OKAY : SLVERR;
                        s_rdata  <= cfg_ack ? cfg_rdata : ERR_RDATA;
                        state    <= RD_RESP;
                    end
                end
                WR_RESP: begin
                    if (s_bready) begin
                        s_bvalid <= 1'b0;
                        aw_held  <= 1'b0;
                        w_held   <= 1'b0;
                        rr_last  <= RR_WRITE;
                        state    <= IDLE;
                    end
                end
                RD_RESP: begin
                    if (s_rready) begin
                        s_rvalid <= 1'b0;
                        rr_last  <= RR_READ;
                        state    <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cl_fsb_cfg_initiator.sv
// tb_cl_fsb_cfg_initiator: randomized scoreboard bench for the cfg initiator.
// Reference model: word memory plus "serve the other kind" arbitration order.
module tb_cl_fsb_cfg_initiator;

    localparam int          TMO  = 8;
    localparam logic [31:0] ERRD = 32'hDEAD_DEAD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_awvalid = 1'b0;
    logic [31:0] s_awaddr = '0;
    logic        s_awready;
    logic        s_wvalid = 1'b0;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wready;
    logic        s_bvalid;
    logic [1:0]  s_bresp;
    logic        s_bready = 1'b0;
    logic        s_arvalid = 1'b0;
    logic [31:0] s_araddr = '0;
    logic        s_arready;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rready = 1'b0;
    logic [31:0] cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_wr;
    logic        cfg_rd;
    logic        resp_ack = 1'b0;
    logic        spur_ack = 1'b0;
    logic [31:0] cfg_rdata = '0;

    cl_fsb_cfg_initiator #(
        .TIMEOUT_CYCLES(TMO),
        .ERR_RDATA     (ERRD)
    ) dut (
        .clk_main_a0(clk),
        .rst_main_n (rst_n),
        .s_awvalid  (s_awvalid),
        .s_awaddr   (s_awaddr),
        .s_awready  (s_awready),
        .s_wvalid   (s_wvalid),
        .s_wdata    (s_wdata),
        .s_wstrb    (s_wstrb),
        .s_wready   (s_wready),
        .s_bvalid   (s_bvalid),
        .s_bresp    (s_bresp),
        .s_bready   (s_bready),
        .s_arvalid  (s_arvalid),
        .s_araddr   (s_araddr),
        .s_arready  (s_arready),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_rready   (s_rready),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_wr     (cfg_wr),
        .cfg_rd     (cfg_rd),
        .cfg_ack    (resp_ack | spur_ack),
        .cfg_rdata  (cfg_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } cfg_t;

    typedef struct {
        logic        wr;
        logic [31:0] data;
        logic [1:0]  resp;
    } rsp_t;

    cfg_t        exp_cfg[$];
    rsp_t        exp_rsp[$];
    logic [31:0] ref_mem[logic [31:0]];
    logic [31:0] slv_mem[logic [31:0]];

    int n_chk     = 0;
    int n_fail    = 0;
    int ack_dly   = 0;
    bit no_ack    = 1'b0;
    int rdy_mode  = 1;
    int ar_hs     = 0;
    int rd_issued = 0;
    bit last_wr   = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic bad(input string nm);
        n_chk++;
        n_fail++;
        $display("FAIL %s: event not expected or bound expired", nm);
    endtask

    function automatic logic [31:0] init_val(input logic [31:0] a);
        return a ^ 32'h5A5A_0F0F;
    endfunction

    // Reference model: predicted cfg traffic and host responses.
    task automatic model_wr(input logic [31:0] a, input logic [31:0] d);
        exp_cfg.push_back('{1'b1, a, d});
        exp_rsp.push_back('{1'b1, 32'h0, 2'b00});
        ref_mem[a] = d;
        last_wr = 1'b1;
    endtask

    task automatic model_rd(input logic [31:0] a);
        logic [31:0] v;
        v = ref_mem.exists(a) ? ref_mem[a] : init_val(a);
        exp_cfg.push_back('{1'b0, a, 32'h0});
        exp_rsp.push_back('{1'b0, v, 2'b00});
        last_wr = 1'b0;
    endtask

    // cfg responder: acks after ack_dly cycles and checks request shape.
    initial begin : responder
        bit          busy = 1'b0;
        int          hi = 0;
        int          cnt = 0;
        int          d = 0;
        logic [31:0] a0 = '0;
        logic [31:0] w0 = '0;
        cfg_t        e;
        forever begin
            @(posedge clk);
            #1;
            resp_ack  = 1'b0;
            cfg_rdata = $urandom;
            if (!rst_n) begin
                busy = 1'b0;
                continue;
            end
            if (cfg_wr || cfg_rd) begin
                chk("cfg_excl", 32'(cfg_wr & cfg_rd), 0);
                if (!busy) begin
                    busy = 1'b1;
                    hi   = 0;
                    d    = ack_dly;
                    cnt  = d;
                    a0   = cfg_addr;
                    w0   = cfg_wdata;
                    if (exp_cfg.size() == 0) begin
                        bad("cfg_unexpected");
                    end else begin
                        e = exp_cfg.pop_front();
                        chk("cfg_kind", 32'(cfg_wr), 32'(e.wr));
                        chk("cfg_addr", cfg_addr, e.addr);
                        if (e.wr) chk("cfg_wdata", cfg_wdata, e.data);
                    end
                end else begin
                    chk("cfg_addr_stable", cfg_addr, a0);
                    chk("cfg_wdata_stable", cfg_wdata, w0);
                end
                hi++;
                if (!no_ack) begin
                    if (cnt == 0) begin
                        resp_ack = 1'b1;
                        if (cfg_wr) slv_mem[cfg_addr] = cfg_wdata;
                        else cfg_rdata = slv_mem.exists(cfg_addr) ?
                                         slv_mem[cfg_addr] : init_val(cfg_addr);
                    end else begin
                        cnt--;
                    end
                end
            end else if (busy) begin
                busy = 1'b0;
                chk("req_cycles", hi, no_ack ? TMO : d + 1);
                chk("resp_latency", 32'(s_bvalid | s_rvalid), 1);
            end
        end
    end

    // Host-side monitor: pops the scoreboard on each B/R handshake.
    initial begin : monitor
        bit          pb = 1'b0;
        bit          pr = 1'b0;
        logic [1:0]  pbresp = '0;
        logic [31:0] prdata = '0;
        rsp_t        e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pb = 1'b0;
                pr = 1'b0;
                continue;
            end
            if (pb) begin
                chk("bvalid_hold", 32'(s_bvalid), 1);
                chk("bresp_hold", 32'(s_bresp), 32'(pbresp));
            end
            if (pr) begin
                chk("rvalid_hold", 32'(s_rvalid), 1);
                chk("rdata_hold", s_rdata, prdata);
            end
            pb     = s_bvalid && !s_bready;
            pbresp = s_bresp;
            pr     = s_rvalid && !s_rready;
            prdata = s_rdata;
            if (s_arvalid && s_arready) ar_hs++;
            if (s_bvalid && s_bready) begin
                if (exp_rsp.size() == 0) begin
                    bad("b_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("b_kind", 32'(e.wr), 1);
                    chk("bresp", 32'(s_bresp), 32'(e.resp));
                end
            end
            if (s_rvalid && s_rready) begin
                if (exp_rsp.size() == 0) begin
                    bad("r_unexpected");
                end else begin
                    e = exp_rsp.pop_front();
                    chk("r_kind", 32'(e.wr), 0);
                    chk("rdata", s_rdata, e.data);
                    chk("rresp", 32'(s_rresp), 32'(e.resp));
                end
            end
        end
    end

    // Response-ready driver: random, held high, or R stalled.
    initial begin : readies
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: begin
                    s_bready = ($urandom_range(0, 2) != 0);
                    s_rready = ($urandom_range(0, 2) != 0);
                end
                1: begin
                    s_bready = 1'b1;
                    s_rready = 1'b1;
                end
                default: begin
                    s_bready = 1'b1;
                    s_rready = 1'b0;
                end
            endcase
        end
    end

    task automatic send_aw(input logic [31:0] a, input int dly);
        bit ok = 1'b0;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        s_awvalid = 1'b1;
        s_awaddr  = a;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = s_awready;
            @(posedge clk);
            #1;
        end
        s_awvalid = 1'b0;
        s_awaddr  = $urandom;
        if (!ok) bad("aw_timeout");
    endtask

    task automatic send_w(input logic [31:0] d, input int dly);
        bit ok = 1'b0;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        s_wvalid = 1'b1;
        s_wdata  = d;
        s_wstrb  = 4'($urandom);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = s_wready;
            @(posedge clk);
            #1;
        end
        s_wvalid = 1'b0;
        s_wdata  = $urandom;
        if (!ok) bad("w_timeout");
    endtask

    task automatic send_ar(input logic [31:0] a, input int dly);
        bit ok = 1'b0;
        repeat (dly) begin
            @(posedge clk);
            #1;
        end
        s_arvalid = 1'b1;
        s_araddr  = a;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = s_arready;
            @(posedge clk);
            #1;
        end
        s_arvalid = 1'b0;
        s_araddr  = $urandom;
        if (ok) rd_issued++;
        else bad("ar_timeout");
    endtask

    task automatic host_write(input logic [31:0] a, input logic [31:0] d,
                              input int awd, input int wd);
        model_wr(a, d);
        fork
            send_aw(a, awd);
            send_w(d, wd);
        join
    endtask

    task automatic host_read(input logic [31:0] a);
        model_rd(a);
        send_ar(a, 0);
    endtask

    // Write halves land first, AR one cycle later: both pending in IDLE.
    task automatic both_pending(input logic [31:0] wa, input logic [31:0] wd,
                                input logic [31:0] ra);
        if (last_wr) begin
            model_rd(ra);
            model_wr(wa, wd);
        end else begin
            model_wr(wa, wd);
            model_rd(ra);
        end
        fork
            send_aw(wa, 0);
            send_w(wd, 0);
            send_ar(ra, 1);
        join
    endtask

    task automatic wait_idle();
        int i = 0;
        while ((exp_rsp.size() != 0 || exp_cfg.size() != 0) && i < 400) begin
            @(negedge clk);
            i++;
        end
        @(posedge clk);
        #1;
        chk("drain", 32'(exp_rsp.size() + exp_cfg.size()), 0);
    endtask

    task automatic quiet_check(input string nm);
        repeat (3) begin
            @(negedge clk);
            chk(nm, 32'({cfg_wr, cfg_rd, s_bvalid, s_rvalid}), 0);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic spur_pulse();
        @(posedge clk);
        #1;
        spur_ack = 1'b1;
        @(posedge clk);
        #1;
        spur_ack = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit expired");
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin : main
        int          k;
        int          ar0;
        logic [31:0] a;
        logic [31:0] a2;

        ref_mem[32'h40] = 32'h1234_5678;
        slv_mem[32'h40] = 32'h1234_5678;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_ctrl", 32'({cfg_wr, cfg_rd, s_bvalid, s_rvalid, s_arready,
                             s_bresp, s_rresp}), 0);
        chk("rst_cfg_addr", cfg_addr, 0);
        chk("rst_cfg_wdata", cfg_wdata, 0);
        chk("rst_rdata", s_rdata, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // AW and W together; cfg_wr held 2 cycles.
        rdy_mode = 1;
        ack_dly  = 1;
        host_write(32'h10, 32'hCAFE_0001, 0, 0);
        wait_idle();

        // W three cycles before AW: nothing issued until AW lands.
        ack_dly = 0;
        fork
            host_write(32'h20, 32'h5, 3, 0);
            begin
                @(posedge clk);
                repeat (2) begin
                    @(negedge clk);
                    chk("wready_while_held", 32'(s_wready), 0);
                    chk("no_early_wr", 32'(cfg_wr), 0);
                end
            end
        join
        wait_idle();

        // Read with R stalled four cycles.
        rdy_mode = 2;
        ack_dly  = 1;
        ar0      = ar_hs;
        host_read(32'h40);
        for (int i = 0; i < 50 && !s_rvalid; i++) @(negedge clk);
        chk("rvalid_seen", 32'(s_rvalid), 1);
        repeat (4) begin
            @(negedge clk);
            chk("r_stall_valid", 32'(s_rvalid), 1);
            chk("r_stall_data", s_rdata, 32'h1234_5678);
        end
        @(posedge clk);
        #1;
        rdy_mode = 1;
        wait_idle();
        chk("ar_once", 32'(ar_hs - ar0), 1);

        // Arbitration: last served was a read, so the write goes first.
        both_pending(32'h50, 32'h1111_0000, 32'h50);
        wait_idle();
        host_write(32'h58, 32'h2222_0000, 0, 1);
        wait_idle();
        both_pending(32'h5C, 32'h3333_0000, 32'h58);
        wait_idle();

        // Stray ack while idle.
        spur_pulse();
        quiet_check("spur_quiet");

        // Randomized mix against the reference model.
        for (int n = 0; n < 60; n++) begin
            rdy_mode = $urandom_range(0, 1);
            ack_dly  = $urandom_range(0, 3);
            k        = $urandom_range(0, 4);
            a        = 32'($urandom_range(0, 15)) << 2;
            a2       = 32'($urandom_range(0, 15)) << 2;
            if (k < 2) host_write(a, $urandom, $urandom_range(0, 3),
                                  $urandom_range(0, 3));
            else if (k < 4) host_read(a);
            else both_pending(a, $urandom, a2);
            wait_idle();
        end
        rdy_mode = 1;

`ifdef CFG_INIT_TIMEOUT_EN
        // No ack: SLVERR and error pattern after TMO request cycles.
        no_ack = 1'b1;
        exp_cfg.push_back('{1'b0, 32'h60, 32'h0});
        exp_rsp.push_back('{1'b0, ERRD, 2'b10});
        last_wr = 1'b0;
        send_ar(32'h60, 0);
        wait_idle();
        spur_pulse();
        quiet_check("late_ack_quiet");
        no_ack = 1'b0;

        // Ack on the terminal count still gives OKAY.
        ack_dly = TMO - 1;
        host_read(32'h64);
        wait_idle();
        ack_dly = 0;
`endif

        // Reset in the middle of a read, with a lone W held.
        no_ack = 1'b1;
        send_w(32'h77, 0);
        host_read(32'h80);
        for (int i = 0; i < 20 && !cfg_rd; i++) @(negedge clk);
        chk("rd_before_rst", 32'(cfg_rd), 1);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ctrl", 32'({cfg_wr, cfg_rd, s_bvalid, s_rvalid,
                                 s_arready, s_bresp, s_rresp}), 0);
        chk("mid_rst_addr", cfg_addr, 0);
        chk("mid_rst_rdata", s_rdata, 0);
        exp_cfg.delete();
        exp_rsp.delete();
        last_wr = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        no_ack = 1'b0;
        @(negedge clk);
        chk("w_discarded", 32'(s_wready), 1);
        chk("aw_free", 32'(s_awready), 1);
        @(posedge clk);
        #1;
        host_read(32'h80);
        wait_idle();
        host_write(32'h84, 32'hA5A5_5A5A, 1, 0);
        wait_idle();
        host_read(32'h84);
        wait_idle();

        chk("ar_total", ar_hs, rd_issued);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
